// File: rtl/ctrl_decode_pipe_if.sv
// Decode-to-execute control bundle: decode-side inputs, combinational immediate
// select and the registered E-stage controls of ctrl_decode_pipe.
interface ctrl_decode_pipe_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic [6:0]       Op;
    logic             stall;
    logic             flush;
    logic [2:0]       ImmSrcD;
    logic             out_valid;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             ALUSrcE;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    logic             AuipcE;
    logic [1:0]       ResultSrcE;
    logic [1:0]       ALUOpE;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, Op, stall, flush,
        input  ImmSrcD, out_valid, RegWriteE, MemWriteE, ALUSrcE, BranchE,
               JumpE, JalrE, AuipcE, ResultSrcE, ALUOpE, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, Op, stall, flush,
        output ImmSrcD, out_valid, RegWriteE, MemWriteE, ALUSrcE, BranchE,
               JumpE, JalrE, AuipcE, ResultSrcE, ALUOpE, illegal, illegal_cnt
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Main-decoder control unit with a stallable/flushable D->E control register
// and a saturating counter of accepted illegal opcodes.
module ctrl_decode_pipe #(
    parameter int EXT_OPS = 1,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    ctrl_decode_pipe_if.slave bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_BRCMP = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        logic    alu_src;
        logic    branch;
        logic    jump;
        logic    jalr;
        logic    auipc;
        result_e result_src;
        aluop_e  alu_op;
    } ctrl_t;

    ctrl_t            dec_ctrl;
    logic             dec_legal;
    imm_e             imm_src;
    logic             accept;

    ctrl_t            ctrl_d,        ctrl_q;
    logic             out_valid_d,   out_valid_q;
    logic             illegal_d,     illegal_q;
    logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;

    // NOTE: every always_comb output gets a default before the case so that
    // unlisted opcodes cannot leave a path unassigned and infer a latch.
    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b0;
        imm_src   = IMM_I;
        case (bus.Op)
            OP_LOAD: begin
                dec_legal = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec_legal = 1'b1;
                imm_src   = IMM_S;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_RTYPE: begin
                dec_legal = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_BRANCH: begin
                dec_legal = 1'b1;
                imm_src   = IMM_B;
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_BRCMP;
            end
            OP_IALU: begin
                dec_legal = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_JAL: if (EXT_OPS != 0) begin
                dec_legal = 1'b1;
                imm_src   = IMM_J;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.result_src = RES_PC4;
            end
            OP_JALR: if (EXT_OPS != 0) begin
                dec_legal = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.jalr       = 1'b1;
                dec_ctrl.result_src = RES_PC4;
            end
            OP_LUI: if (EXT_OPS != 0) begin
                dec_legal = 1'b1;
                imm_src   = IMM_U;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = RES_IMM;
            end
            OP_AUIPC: if (EXT_OPS != 0) begin
                dec_legal = 1'b1;
                imm_src   = IMM_U;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.auipc     = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = bus.in_valid & ~bus.stall & ~bus.flush;

    // Flush beats stall; a stall holds the whole E register, including out_valid.
    always_comb begin
        ctrl_d      = ctrl_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            ctrl_d      = '0;
            out_valid_d = 1'b0;
        end else if (!bus.stall) begin
            out_valid_d = bus.in_valid & dec_legal;
            ctrl_d      = out_valid_d ? dec_ctrl : '0;
        end

        illegal_d     = accept & ~dec_legal;
        illegal_cnt_d = illegal_cnt_q;
        if (illegal_d && (illegal_cnt_q != CNT_MAX)) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q        <= '0;
            out_valid_q   <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            out_valid_q   <= out_valid_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.ImmSrcD     = imm_src;
    assign bus.out_valid   = out_valid_q;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.ALUSrcE     = ctrl_q.alu_src;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.JalrE       = ctrl_q.jalr;
    assign bus.AuipcE      = ctrl_q.auipc;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.ALUOpE      = ctrl_q.alu_op;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (EXT_OPS=1/CNT_W=8 and EXT_OPS=0/CNT_W=2)
// share directed and random stimulus and are compared to a table-driven model.
module tb_ctrl_decode_pipe;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RT    = 7'b0110011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] IALU  = 7'b0010011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    // Control vector order: RegWrite MemWrite ALUSrc Branch Jump Jalr Auipc ResultSrc[1:0] ALUOp[1:0]
    typedef struct {
        logic [10:0] ctrl;
        logic [10:0] mask;
        logic [2:0]  imm;
        bit          legal;
    } dec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_decode_pipe_if #(.CNT_W(8)) if_a ();
    ctrl_decode_pipe_if #(.CNT_W(2)) if_b ();

    ctrl_decode_pipe #(.EXT_OPS(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    ctrl_decode_pipe #(.EXT_OPS(0), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    logic [10:0] act_ctrl  [2];
    logic        act_valid [2];
    logic        act_ill   [2];
    logic [15:0] act_cnt   [2];
    logic [2:0]  act_imm   [2];

    assign act_ctrl[0]  = {if_a.RegWriteE, if_a.MemWriteE, if_a.ALUSrcE, if_a.BranchE, if_a.JumpE,
                           if_a.JalrE, if_a.AuipcE, if_a.ResultSrcE, if_a.ALUOpE};
    assign act_ctrl[1]  = {if_b.RegWriteE, if_b.MemWriteE, if_b.ALUSrcE, if_b.BranchE, if_b.JumpE,
                           if_b.JalrE, if_b.AuipcE, if_b.ResultSrcE, if_b.ALUOpE};
    assign act_valid[0] = if_a.out_valid;
    assign act_valid[1] = if_b.out_valid;
    assign act_ill[0]   = if_a.illegal;
    assign act_ill[1]   = if_b.illegal;
    assign act_cnt[0]   = 16'(if_a.illegal_cnt);
    assign act_cnt[1]   = 16'(if_b.illegal_cnt);
    assign act_imm[0]   = if_a.ImmSrcD;
    assign act_imm[1]   = if_b.ImmSrcD;

    bit          ext      [2] = '{1'b1, 1'b0};
    int          cnt_max  [2] = '{255, 3};
    logic [10:0] exp_ctrl [2];
    logic [10:0] exp_mask [2];
    bit          exp_valid[2];
    bit          exp_ill  [2];
    int          exp_cnt  [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] pk(bit rw, bit mw, bit as, bit br, bit jp, bit jr, bit ap,
                                       logic [1:0] rs, logic [1:0] ao);
        return {rw, mw, as, br, jp, jr, ap, rs, ao};
    endfunction

    // Straight transcription of the decode table; ext opcodes vanish when ext=0.
    function automatic dec_t ref_decode(logic [6:0] op, bit e);
        dec_t d;
        d.ctrl = '0; d.mask = 11'h7FF; d.imm = 3'b000; d.legal = 1'b0;
        case (op)
            LW:   begin d.legal = 1; d.ctrl = pk(1,0,1,0,0,0,0,2'b01,2'b00); end
            SW:   begin d.legal = 1; d.imm = 3'b001; d.ctrl = pk(0,1,1,0,0,0,0,2'b00,2'b00); end
            RT:   begin d.legal = 1; d.ctrl = pk(1,0,0,0,0,0,0,2'b00,2'b10); end
            BEQ:  begin d.legal = 1; d.imm = 3'b010; d.ctrl = pk(0,0,0,1,0,0,0,2'b00,2'b01); end
            IALU: begin d.legal = 1; d.ctrl = pk(1,0,1,0,0,0,0,2'b00,2'b10); end
            JAL:  if (e) begin
                d.legal = 1; d.imm = 3'b011; d.ctrl = pk(1,0,0,0,1,0,0,2'b10,2'b00);
                d.mask = 11'h6FF;  // ALUSrc is don't-care for jal
            end
            JALR: if (e) begin d.legal = 1; d.ctrl = pk(1,0,1,0,1,1,0,2'b10,2'b00); end
            LUI:  if (e) begin d.legal = 1; d.imm = 3'b100; d.ctrl = pk(1,0,1,0,0,0,0,2'b11,2'b00); end
            AUIPC: if (e) begin d.legal = 1; d.imm = 3'b100; d.ctrl = pk(1,0,1,0,0,0,1,2'b00,2'b00); end
            default: ;
        endcase
        return d;
    endfunction

    // One clock: drive inputs, check the combinational ImmSrcD, advance the
    // model, cross the edge and check the registered outputs.
    task automatic cycle(input bit r, input bit iv, input logic [6:0] op, input bit st, input bit fl);
        dec_t d;
        bit   acc;
        rst = r;
        if_a.in_valid = iv; if_a.Op = op; if_a.stall = st; if_a.flush = fl;
        if_b.in_valid = iv; if_b.Op = op; if_b.stall = st; if_b.flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            d = ref_decode(op, ext[k]);
            check($sformatf("imm[%0d] op=%07b", k, op), 32'(act_imm[k]), 32'(d.imm));
            if (r) begin
                exp_valid[k] = 0; exp_ctrl[k] = '0; exp_mask[k] = 11'h7FF;
                exp_ill[k] = 0; exp_cnt[k] = 0;
            end else begin
                acc = iv && !st && !fl;
                exp_ill[k] = acc && !d.legal;
                if (exp_ill[k] && exp_cnt[k] < cnt_max[k]) exp_cnt[k] = exp_cnt[k] + 1;
                if (fl) begin
                    exp_valid[k] = 0; exp_ctrl[k] = '0; exp_mask[k] = 11'h7FF;
                end else if (!st) begin
                    exp_valid[k] = iv && d.legal;
                    exp_ctrl[k]  = exp_valid[k] ? d.ctrl : 11'h000;
                    exp_mask[k]  = exp_valid[k] ? d.mask : 11'h7FF;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid[%0d]", k), 32'(act_valid[k]), 32'(exp_valid[k]));
            check($sformatf("ctrl[%0d]", k), 32'(act_ctrl[k] & exp_mask[k]), 32'(exp_ctrl[k]));
            check($sformatf("illegal[%0d]", k), 32'(act_ill[k]), 32'(exp_ill[k]));
            check($sformatf("cnt[%0d]", k), 32'(act_cnt[k]), 32'(exp_cnt[k]));
        end
    endtask

    logic [6:0] pool [9] = '{LW, SW, RT, BEQ, IALU, JAL, JALR, LUI, AUIPC};

    initial begin
        logic [6:0] op;
        for (int k = 0; k < 2; k++) begin
            exp_valid[k] = 0; exp_ctrl[k] = '0; exp_mask[k] = 11'h7FF;
            exp_ill[k] = 0; exp_cnt[k] = 0;
        end
        @(posedge clk);
        #1;
        cycle(1, 1, LW, 1, 1);
        cycle(1, 0, 7'h00, 0, 0);

        // lw, then a bubble from in_valid=0
        cycle(0, 1, LW, 0, 0);
        cycle(0, 0, LW, 0, 0);

        // beq held through three stall cycles, sw follows once released
        cycle(0, 1, BEQ, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, SW, 1, 0);
        cycle(0, 1, SW, 0, 0);

        // flush with stall: bubble, no illegal pulse for an illegal Op
        cycle(0, 1, RT, 0, 0);
        cycle(0, 1, 7'h00, 1, 1);

        // jal: legal on the extended instance, illegal on the base one
        cycle(0, 1, JAL, 0, 0);
        cycle(0, 0, JAL, 0, 0);

        // illegal count saturation, then an illegal Op under stall
        for (int i = 0; i < 5; i++) cycle(0, 1, 7'h00, 0, 0);
        cycle(0, 1, 7'h00, 1, 0);

        // reset during stall drops the held lui, auipc loads afterwards
        cycle(0, 1, LUI, 0, 0);
        cycle(1, 1, LUI, 1, 0);
        cycle(0, 1, AUIPC, 0, 0);
        cycle(0, 1, JALR, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) op = 7'($urandom);
            else op = pool[$urandom_range(0, 8)];
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  op,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 Parameter EXT_OPS, default 1, meaning: 1 = decode jal/jalr/lui/auipc in addition to the base set; 0 = base set only, all others illegal.
REQ-002 Parameter CNT_W, default 8, meaning: width of the illegal-opcode counter, legal range 1..16.
REQ-003 clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-004 rst  input  1  meaning: synchronous, active-high reset.
REQ-005 in_valid  input  1  meaning: Op carries a decode-stage instruction.
REQ-006 Op  input  7  meaning: instruction opcode bits [6:0].
REQ-007 stall  input  1  meaning: hold the E-stage control register.
REQ-008 flush  input  1  meaning: load a bubble into the E-stage control register.
REQ-009 ImmSrcD  output  3  meaning: combinational immediate-format select for the decode stage: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-010 out_valid, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, AuipcE  output  1 each  meaning: registered E-stage controls.
REQ-011 ResultSrcE  output  2  meaning: 00 ALU, 01 memory, 10 PC+4, 11 immediate (lui).
REQ-012 ALUOpE  output  2  meaning: 00 add, 01 branch compare, 10 funct-decoded.
REQ-013 illegal  output  1  meaning: registered one-cycle pulse for an accepted illegal opcode.
REQ-014 illegal_cnt  output  CNT_W  meaning: saturating count of accepted illegal opcodes.

Function
REQ-015 Decode table (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp): 0000011 lw 1,I,1,0,01,0,0,00; 0100011 sw 0,S,1,1,00,0,0,00; 0110011 R 1,I,0,0,00,0,0,10; 1100011 branch 0,B,0,0,00,1,0,01; 0010011 I-ALU 1,I,1,0,00,0,0,10.
REQ-016 With EXT_OPS=1: 1101111 jal 1,J,x,0,10,0,1,00; 1100111 jalr 1,I,1,0,10,0,1,00 with JalrE=1; 0110111 lui 1,U,1,0,11,0,0,00; 0010111 auipc 1,U,1,0,00,0,0,00 with AuipcE=1.
REQ-017 Any other opcode, or an EXT_OPS opcode with EXT_OPS=0, is illegal and decodes to all-zero controls.
REQ-018 ImmSrcD is purely combinational from Op, independent of in_valid, stall and flush; it is 000 for illegal opcodes.
REQ-019 accept = in_valid & ~stall & ~flush.
REQ-020 Register update priority per edge: rst, then flush (bubble), then stall (hold all E outputs), then load.
REQ-021 Load: out_valid <= in_valid & legal; all E controls <= decoded values when out_valid is loaded 1, else all zero; latency exactly one cycle from Op to E outputs.
REQ-022 Bubble: out_valid and every E control <= 0.
REQ-023 illegal <= accept & ~legal on every non-reset edge, including during stall and flush (yielding 0).
REQ-024 illegal_cnt increments by 1 on accept & ~legal; it holds at 2^CNT_W-1; it never wraps.
REQ-025 stall and flush asserted together: flush wins; no count, no illegal pulse.
REQ-026 in_valid=0 without stall/flush loads a bubble regardless of Op.

Reset
REQ-027 On rst=1 at a rising edge, out_valid, every E control, ALUOpE, ResultSrcE, illegal and illegal_cnt become 0 on that edge, overriding flush, stall and in_valid.
REQ-028 rst asserted mid-stall discards the held instruction; the first post-reset load behaves as REQ-021.

Verification
REQ-029 Reset, then lw with in_valid=1 -> next cycle out_valid=1, RegWriteE=1, ALUSrcE=1, ResultSrcE=01, ALUOpE=00; ImmSrcD=000 in the same cycle.
REQ-030 beq loaded, then stall=1 for 3 cycles with Op=sw -> BranchE=1, ALUOpE=01 held for all 3 cycles; sw appears one cycle after stall drops.
REQ-031 R-type loaded, then flush=1 with stall=1 -> next cycle all E outputs 0, illegal=0.
REQ-032 EXT_OPS=0, jal with in_valid=1 -> out_valid=0, illegal=1 for one cycle, illegal_cnt=1; EXT_OPS=1 same stimulus -> JumpE=1, ResultSrcE=10, ImmSrcD=011.
REQ-033 CNT_W=2, 5 accepted illegal opcodes (0000000) -> illegal_cnt 1,2,3,3,3; illegal pulses 5 times; an illegal opcode under stall -> no change.
REQ-034 lui loaded, rst=1 with stall=1 -> next cycle all outputs 0; after release, auipc -> AuipcE=1, ImmSrcD=100, ResultSrcE=00.
